// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the
// per-stage control vector with its canned values.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_MD_WAIT  = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic pc_sel_br;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic exmem_flush;
    logic memwb_we;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{
    pc_we: 1'b1, pc_sel_br: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b0,
    idex_we: 1'b1, idex_flush: 1'b0, exmem_we: 1'b1, exmem_flush: 1'b0,
    memwb_we: 1'b1
  };

  localparam ctrl_t CTRL_FREEZE = '0;

  localparam ctrl_t CTRL_INIT = '{
    pc_we: 1'b0, pc_sel_br: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
    idex_we: 1'b0, idex_flush: 1'b1, exmem_we: 1'b0, exmem_flush: 1'b1,
    memwb_we: 1'b0
  };

  // Front end held while the mul/div runs; EX/MEM takes bubbles, MEM/WB drains.
  localparam ctrl_t CTRL_MD_HOLD = '{
    pc_we: 1'b0, pc_sel_br: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
    idex_we: 1'b0, idex_flush: 1'b0, exmem_we: 1'b1, exmem_flush: 1'b1,
    memwb_we: 1'b1
  };

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module pipeline_stall_ctrl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignment keeps register updates independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central 5-stage pipeline sequencer: folds hazard stall, branch redirect,
// data-memory wait and mul/div busy into per-stage enables and flushes.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             perf_clr,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             exmem_flush,
  output logic             memwb_we,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              MD_W    = $clog2(MD_TIMEOUT);
  localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic            md_err_q, md_err_d;
  logic            done_pend_q, done_pend_d;

  ctrl_t  ctrl;
  logic   br_flush;

  ctrl_t  run_ctrl;
  state_e run_next;
  logic   run_md_go;
  logic   run_br;

  // RUN decision; MEM_WAIT reuses it because a still-busy memory yields the
  // same freeze and stays in MEM_WAIT.
  always_comb begin
    run_ctrl  = CTRL_NORMAL;
    run_next  = ST_RUN;
    run_md_go = 1'b0;
    run_br    = 1'b0;
    if (mem_busy) begin
      run_ctrl = CTRL_FREEZE;
      run_next = ST_MEM_WAIT;
    end else if (md_start) begin
      run_ctrl  = CTRL_MD_HOLD;
      run_next  = ST_MD_WAIT;
      run_md_go = 1'b1;
    end else if (hz_stall) begin
      run_ctrl.pc_we      = 1'b0;
      run_ctrl.ifid_we    = 1'b0;
      run_ctrl.idex_flush = 1'b1;
    end else if (br_taken) begin
      run_ctrl.pc_sel_br  = 1'b1;
      run_ctrl.ifid_flush = 1'b1;
      run_br              = 1'b1;
    end
  end

  always_comb begin
    ctrl        = CTRL_FREEZE;
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    md_err_d    = md_err_q;
    done_pend_d = done_pend_q;
    br_flush    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        ctrl    = CTRL_INIT;
        state_d = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        ctrl     = run_ctrl;
        state_d  = run_next;
        br_flush = run_br;
        if (run_md_go) begin
          md_cnt_d    = '0;
          done_pend_d = 1'b0;
        end
      end
      ST_MD_WAIT: begin
        if (!mem_busy && (md_done || done_pend_q)) begin
          ctrl         = CTRL_MD_HOLD;
          ctrl.idex_we = 1'b1;
          state_d      = ST_RUN;
          done_pend_d  = 1'b0;
        end else if (mem_busy) begin
          // A completion during a memory freeze is remembered, and the timeout
          // count parks at its last value so it cannot wrap past expiry.
          ctrl = CTRL_FREEZE;
          if (md_done) done_pend_d = 1'b1;
          if (md_cnt_q != MD_LAST) md_cnt_d = md_cnt_q + MD_W'(1);
        end else begin
          ctrl = CTRL_MD_HOLD;
          if (md_cnt_q == MD_LAST) begin
            md_err_d = 1'b1;
            state_d  = ST_RUN;
          end else begin
            md_cnt_d = md_cnt_q + MD_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      md_cnt_q    <= '0;
      md_err_q    <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_err_q    <= md_err_d;
      done_pend_q <= done_pend_d;
    end
  end

  pipeline_stall_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i ((state_q != ST_INIT) && !ctrl.pc_we),
    .clr_i (perf_clr),
    .cnt_o (stall_cnt)
  );

  pipeline_stall_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (br_flush),
    .clr_i (perf_clr),
    .cnt_o (flush_cnt)
  );

  assign pc_we       = ctrl.pc_we;
  assign pc_sel_br   = ctrl.pc_sel_br;
  assign ifid_we     = ctrl.ifid_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_we     = ctrl.idex_we;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_we    = ctrl.exmem_we;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_we    = ctrl.memwb_we;
  assign md_err      = md_err_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl: the driver queues the
// expected per-cycle response, a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  // Control vector order: pc_we pc_sel_br ifid_we ifid_flush idex_we idex_flush exmem_we exmem_flush memwb_we
  localparam logic [8:0] C_NORM = 9'b101010101;
  localparam logic [8:0] C_INIT = 9'b000101010;
  localparam logic [8:0] C_FRZ  = 9'b000000000;
  localparam logic [8:0] C_MDH  = 9'b000000111;
  localparam logic [8:0] C_MDD  = 9'b000010111;
  localparam logic [8:0] C_HZ   = 9'b000011101;
  localparam logic [8:0] C_BR   = 9'b111110101;

  // Input vector order: hz_stall br_taken mem_busy md_start md_done perf_clr
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_HZ   = 6'b100000;
  localparam logic [5:0] I_BR   = 6'b010000;
  localparam logic [5:0] I_MB   = 6'b001000;
  localparam logic [5:0] I_MDS  = 6'b000100;
  localparam logic [5:0] I_MDD  = 6'b000010;
  localparam logic [5:0] I_CLR  = 6'b000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hz_stall = 1'b0, br_taken = 1'b0, mem_busy = 1'b0;
  logic md_start = 1'b0, md_done = 1'b0, perf_clr = 1'b0;
  logic pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_flush;
  logic exmem_we, exmem_flush, memwb_we, md_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string      name;
    logic [8:0] ctrl;
    int         stall;
    int         flush;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hz_stall   (hz_stall),
    .br_taken   (br_taken),
    .mem_busy   (mem_busy),
    .md_start   (md_start),
    .md_done    (md_done),
    .perf_clr   (perf_clr),
    .pc_we      (pc_we),
    .pc_sel_br  (pc_sel_br),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush),
    .idex_we    (idex_we),
    .idex_flush (idex_flush),
    .exmem_we   (exmem_we),
    .exmem_flush(exmem_flush),
    .memwb_we   (memwb_we),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Drive one cycle of inputs and queue the response expected during that cycle.
  task automatic step(input string nm, input logic [5:0] in, input logic [8:0] ec,
                      input int es, input int ef, input logic ee);
    exp_t e;
    {hz_stall, br_taken, mem_busy, md_start, md_done, perf_clr} = in;
    e.name  = nm;
    e.ctrl  = ec;
    e.stall = sat(es);
    e.flush = sat(ef);
    e.err   = ee;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".ctrl"}, 32'({pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we,
                                      idex_flush, exmem_we, exmem_flush, memwb_we}),
              32'(e.ctrl));
        check({e.name, ".stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
        check({e.name, ".flush_cnt"}, 32'(flush_cnt), 32'(e.flush));
        check({e.name, ".md_err"},    32'(md_err),    32'(e.err));
      end
    end
  end

  initial begin : driver
    @(posedge clk);
    #1;
    step("reset",       I_NONE,        C_INIT, 0, 0, 1'b0);
    rst_n = 1'b1;
    step("init",        I_NONE,        C_INIT, 0, 0, 1'b0);
    step("run0",        I_NONE,        C_NORM, 0, 0, 1'b0);
    step("hz",          I_HZ,          C_HZ,   0, 0, 1'b0);
    step("after_hz",    I_NONE,        C_NORM, 1, 0, 1'b0);
    step("br",          I_BR,          C_BR,   1, 0, 1'b0);
    step("after_br",    I_NONE,        C_NORM, 1, 1, 1'b0);
    step("hz_br",       I_HZ | I_BR,   C_HZ,   1, 1, 1'b0);
    step("after_hz_br", I_NONE,        C_NORM, 2, 1, 1'b0);
    // mul/div with done five cycles after start
    step("md_start",    I_MDS,         C_MDH,  2, 1, 1'b0);
    for (int i = 0; i < 4; i++) step("md_wait", I_NONE, C_MDH, 3 + i, 1, 1'b0);
    step("md_done",     I_MDD,         C_MDD,  7, 1, 1'b0);
    step("md_back_run", I_NONE,        C_NORM, 8, 1, 1'b0);
    step("clr_vs_inc",  I_HZ | I_CLR,  C_HZ,   8, 1, 1'b0);
    step("after_clr",   I_NONE,        C_NORM, 0, 0, 1'b0);
    // memory wait from RUN, released straight into a branch
    step("mem_run",     I_MB,          C_FRZ,  0, 0, 1'b0);
    step("mem_wait",    I_MB,          C_FRZ,  1, 0, 1'b0);
    step("mem_rel_br",  I_BR,          C_BR,   2, 0, 1'b0);
    step("after_mem",   I_NONE,        C_NORM, 2, 1, 1'b0);
    // done arrives while memory freezes MD_WAIT
    step("md2_start",   I_MDS,         C_MDH,  2, 1, 1'b0);
    step("md2_wait",    I_NONE,        C_MDH,  3, 1, 1'b0);
    step("md2_mb",      I_MB,          C_FRZ,  4, 1, 1'b0);
    step("md2_mb_done", I_MB | I_MDD,  C_FRZ,  5, 1, 1'b0);
    step("md2_mb3",     I_MB,          C_FRZ,  6, 1, 1'b0);
    step("md2_pend",    I_NONE,        C_MDD,  7, 1, 1'b0);
    step("md2_run",     I_NONE,        C_NORM, 8, 1, 1'b0);
    step("clr2",        I_CLR,         C_NORM, 8, 1, 1'b0);
    // timeout: no done for 64 MD_WAIT cycles; stall_cnt saturates
    step("md3_start",   I_MDS,         C_MDH,  0, 0, 1'b0);
    for (int i = 0; i < 64; i++) step("md3_wait", I_NONE, C_MDH, 1 + i, 0, 1'b0);
    step("md3_err",     I_NONE,        C_NORM, 65, 0, 1'b1);
    step("md3_sticky",  I_MDD,         C_NORM, 65, 0, 1'b1);
    step("err_br",      I_BR,          C_BR,   65, 0, 1'b1);
    step("err_run",     I_NONE,        C_NORM, 65, 1, 1'b1);
    // reset in the middle of MD_WAIT
    step("md4_start",   I_MDS,         C_MDH,  65, 1, 1'b1);
    step("md4_wait0",   I_NONE,        C_MDH,  66, 1, 1'b1);
    step("md4_wait1",   I_NONE,        C_MDH,  67, 1, 1'b1);
    rst_n = 1'b0;
    step("rst_mid",     I_NONE,        C_INIT, 0, 0, 1'b0);
    rst_n = 1'b1;
    step("init2",       I_NONE,        C_INIT, 0, 0, 1'b0);
    step("run2",        I_NONE,        C_NORM, 0, 0, 1'b0);
    step("run2_hz",     I_HZ,          C_HZ,   0, 0, 1'b0);
    step("run2_end",    I_NONE,        C_NORM, 1, 0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
